// File: rtl/out_toggle_monitor.sv
// out_toggle_monitor: counts output-bus bit toggles between consecutive accepted
// samples over a fixed window and folds every sample into a MISR signature.
// Latency: report valid one cycle after the last window sample is accepted.
// Backpressure: report held stable until rpt_ready; samples arriving while a
//   report is pending are dropped, not buffered.
//
// Ports:
//   i_clk, i_rst        clock (rising edge), synchronous active-high reset
//   i_start             arm a new window (only honoured while idle)
//   i_in_valid/i_data_in sample strobe and observed netlist output bus
//   o_busy              high from arming until the report is taken
//   o_rpt_valid/i_rpt_ready report handshake
//   o_rpt_toggles       total toggled bits in window (saturating)
//   o_rpt_max_cycle     largest per-sample toggle count in window
//   o_rpt_samples       samples accepted in window
//   o_rpt_signature     final MISR value
module out_toggle_monitor #(
  parameter int                 WIDTH      = 62,
  parameter int                 WIN_CYCLES = 1000,
  parameter int                 CNT_W      = 32,
  parameter logic [WIDTH-1:0]   MISR_POLY  = 62'h3,
  parameter int                 PC_W       = 6
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_start,
  input  logic             i_in_valid,
  input  logic [WIDTH-1:0] i_data_in,
  output logic             o_busy,
  output logic             o_rpt_valid,
  input  logic             i_rpt_ready,
  output logic [CNT_W-1:0] o_rpt_toggles,
  output logic [PC_W-1:0]  o_rpt_max_cycle,
  output logic [CNT_W-1:0] o_rpt_samples,
  output logic [WIDTH-1:0] o_rpt_signature
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_PRIME  = 2'd1,
    S_RUN    = 2'd2,
    S_REPORT = 2'd3
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;

  logic [WIDTH-1:0] r_prev;
  logic [WIDTH-1:0] r_sig;
  logic [CNT_W-1:0] r_toggles;
  logic [PC_W-1:0]  r_max;
  logic [CNT_W-1:0] r_samples;

  logic [WIDTH-1:0] w_diff;
  logic [PC_W-1:0]  w_pc;
  logic [CNT_W:0]   w_tog_sum;
  logic [CNT_W-1:0] w_tog_sat;
  logic [CNT_W-1:0] w_samples_inc;
  logic [WIDTH-1:0] w_sig_nxt;

  // Per-sample toggle count, purely combinational.
  assign w_diff = i_data_in ^ r_prev;

  always_comb begin
    w_pc = '0;
    for (int i = 0; i < WIDTH; i++) begin
      w_pc = w_pc + PC_W'(w_diff[i]);
    end
  end

  // One extra bit on the sum catches overflow so the total can clamp at all-ones.
  assign w_tog_sum     = {1'b0, r_toggles} + (CNT_W+1)'(w_pc);
  assign w_tog_sat     = w_tog_sum[CNT_W] ? {CNT_W{1'b1}} : w_tog_sum[CNT_W-1:0];
  assign w_samples_inc = r_samples + CNT_W'(1);

  // Shift left, feed back the taps when the bit shifted out is set, fold in the sample.
  assign w_sig_nxt = {r_sig[WIDTH-2:0], 1'b0}
                   ^ (r_sig[WIDTH-1] ? MISR_POLY : {WIDTH{1'b0}})
                   ^ i_data_in;

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:   if (i_start) w_state_nxt = S_PRIME;
      S_PRIME:  if (i_in_valid) w_state_nxt = S_RUN;
      S_RUN:    if (i_in_valid && (w_samples_inc == CNT_W'(WIN_CYCLES))) w_state_nxt = S_REPORT;
      S_REPORT: if (i_rpt_ready) w_state_nxt = S_IDLE;
      default:  w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Accumulators double as the report registers: they freeze once the window
  // closes and keep their value after the handshake until the next arm clears them.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_prev    <= '0;
      r_sig     <= '0;
      r_toggles <= '0;
      r_max     <= '0;
      r_samples <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (i_start) begin
            r_sig     <= '0;
            r_toggles <= '0;
            r_max     <= '0;
            r_samples <= '0;
          end
        end
        S_PRIME: begin
          // The priming sample only sets the toggle reference; nothing is counted.
          if (i_in_valid) begin
            r_prev    <= i_data_in;
            r_sig     <= w_sig_nxt;
            r_samples <= CNT_W'(1);
          end
        end
        S_RUN: begin
          if (i_in_valid) begin
            r_prev    <= i_data_in;
            r_sig     <= w_sig_nxt;
            r_toggles <= w_tog_sat;
            r_samples <= w_samples_inc;
            if (w_pc > r_max) r_max <= w_pc;
          end
        end
        default: ;
      endcase
    end
  end

  assign o_busy          = (r_state != S_IDLE);
  assign o_rpt_valid     = (r_state == S_REPORT);
  assign o_rpt_toggles   = r_toggles;
  assign o_rpt_max_cycle = r_max;
  assign o_rpt_samples   = r_samples;
  assign o_rpt_signature = r_sig;

endmodule

// File: tb/tb_out_toggle_monitor.sv
// Self-checking bench for out_toggle_monitor with a short window (4 samples).
// Expected report values come from the list of accepted samples of each window.
// Inputs driven and outputs sampled on the falling edge.
module tb_out_toggle_monitor;

  localparam int             W    = 62;
  localparam int             WIN  = 4;
  localparam int             CW   = 32;
  localparam int             PW   = 6;
  localparam logic [W-1:0]   POLY = 62'h3;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic          in_valid;
  logic [W-1:0]  data_in;
  logic          busy;
  logic          rpt_valid;
  logic          rpt_ready;
  logic [CW-1:0] rpt_toggles;
  logic [PW-1:0] rpt_max_cycle;
  logic [CW-1:0] rpt_samples;
  logic [W-1:0]  rpt_signature;

  int total = 0;
  int bad   = 0;

  logic [W-1:0] win_q[$];

  out_toggle_monitor #(
    .WIDTH(W), .WIN_CYCLES(WIN), .CNT_W(CW), .MISR_POLY(POLY), .PC_W(PW)
  ) dut (
    .i_clk(clk), .i_rst(rst), .i_start(start), .i_in_valid(in_valid),
    .i_data_in(data_in), .o_busy(busy), .o_rpt_valid(rpt_valid),
    .i_rpt_ready(rpt_ready), .o_rpt_toggles(rpt_toggles),
    .o_rpt_max_cycle(rpt_max_cycle), .o_rpt_samples(rpt_samples),
    .o_rpt_signature(rpt_signature)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [W-1:0] rnd();
    logic [63:0] t;
    t = {$urandom(), $urandom()};
    return t[W-1:0];
  endfunction

  // Reference: toggles are the Hamming distances between neighbouring samples.
  function automatic logic [63:0] m_toggles();
    logic [63:0] t = 0;
    for (int i = 1; i < win_q.size(); i++) t += 64'($countones(win_q[i] ^ win_q[i-1]));
    return t;
  endfunction

  function automatic logic [63:0] m_max();
    int m = 0;
    for (int i = 1; i < win_q.size(); i++)
      if ($countones(win_q[i] ^ win_q[i-1]) > m) m = $countones(win_q[i] ^ win_q[i-1]);
    return 64'(m);
  endfunction

  // Reference signature: repeated multiply-by-x modulo the feedback polynomial, plus sample.
  function automatic logic [W-1:0] m_sig();
    logic [W-1:0] s = '0;
    logic         top;
    foreach (win_q[i]) begin
      top = s[W-1];
      s   = (s << 1) ^ win_q[i];
      if (top) s = s ^ POLY;
    end
    return s;
  endfunction

  task automatic send(input logic [W-1:0] d, input int gap, input bit rec);
    repeat (gap) begin
      in_valid = 1'b0;
      data_in  = rnd();
      @(negedge clk);
    end
    in_valid = 1'b1;
    data_in  = d;
    if (rec) win_q.push_back(d);
    @(negedge clk);
    in_valid = 1'b0;
    data_in  = rnd();
  endtask

  task automatic begin_win();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    win_q.delete();
    check("arm_busy", 64'(busy), 64'd1);
    check("arm_clear_tog", 64'(rpt_toggles), 64'd0);
    check("arm_clear_sig", 64'(rpt_signature), 64'd0);
  endtask

  task automatic run_win(input logic [W-1:0] d[4], input int maxgap);
    for (int i = 0; i < WIN; i++) begin
      send(d[i], $urandom_range(0, maxgap), 1'b1);
      check(i < WIN-1 ? "valid_early" : "valid_latency", 64'(rpt_valid), (i < WIN-1) ? 64'd0 : 64'd1);
    end
  endtask

  task automatic check_report(input string tag);
    check({tag, "_toggles"}, 64'(rpt_toggles), m_toggles());
    check({tag, "_max"}, 64'(rpt_max_cycle), m_max());
    check({tag, "_samples"}, 64'(rpt_samples), 64'(WIN));
    check({tag, "_sig"}, 64'(rpt_signature), 64'(m_sig()));
  endtask

  task automatic take_report(input string tag);
    rpt_ready = 1'b1;
    @(negedge clk);
    rpt_ready = 1'b0;
    check({tag, "_valid_drop"}, 64'(rpt_valid), 64'd0);
    check({tag, "_idle"}, 64'(busy), 64'd0);
    check_report({tag, "_held"});
  endtask

  initial begin
    logic [W-1:0] v[4];
    rst = 1'b1; start = 1'b0; in_valid = 1'b0; data_in = '0; rpt_ready = 1'b0;

    // Reset values
    repeat (3) @(negedge clk);
    rst = 1'b0;
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_valid", 64'(rpt_valid), 64'd0);
    check("rst_toggles", 64'(rpt_toggles), 64'd0);
    check("rst_max", 64'(rpt_max_cycle), 64'd0);
    check("rst_samples", 64'(rpt_samples), 64'd0);
    check("rst_sig", 64'(rpt_signature), 64'd0);

    // Samples while idle are ignored
    send(rnd(), 0, 1'b0);
    check("idle_ignore_busy", 64'(busy), 64'd0);
    check("idle_ignore_samples", 64'(rpt_samples), 64'd0);

    // Full-swing window
    begin_win();
    v[0] = '0; v[1] = {W{1'b1}}; v[2] = '0; v[3] = {W{1'b1}};
    run_win(v, 0);
    check_report("swing");
    check("swing_toggles_const", 64'(rpt_toggles), 64'd186);
    check("swing_max_const", 64'(rpt_max_cycle), 64'd62);
    // Handshake with a simultaneous start: start must be ignored
    rpt_ready = 1'b1; start = 1'b1;
    @(negedge clk);
    rpt_ready = 1'b0; start = 1'b0;
    check("hs_start_busy", 64'(busy), 64'd0);
    check("hs_start_valid", 64'(rpt_valid), 64'd0);
    check("hs_start_held", 64'(rpt_toggles), 64'd186);

    // Constant data
    begin_win();
    v[0] = 62'h155; v[1] = 62'h155; v[2] = 62'h155; v[3] = 62'h155;
    run_win(v, 0);
    check_report("const");
    check("const_toggles_zero", 64'(rpt_toggles), 64'd0);
    take_report("const");

    // Single-bit steps with gaps
    begin_win();
    v[0] = 62'h0; v[1] = 62'h1; v[2] = 62'h3; v[3] = 62'h3;
    run_win(v, 3);
    check_report("gaps");
    check("gaps_toggles_const", 64'(rpt_toggles), 64'd2);
    check("gaps_max_const", 64'(rpt_max_cycle), 64'd1);
    take_report("gaps");

    // Backpressure: start and samples during a stalled report change nothing
    begin_win();
    for (int i = 0; i < WIN; i++) v[i] = rnd();
    run_win(v, 1);
    for (int i = 0; i < 10; i++) begin
      start    = (i % 2 == 0);
      in_valid = 1'b1;
      data_in  = rnd();
      @(negedge clk);
      check("stall_valid", 64'(rpt_valid), 64'd1);
      check("stall_busy", 64'(busy), 64'd1);
      check_report("stall");
    end
    start = 1'b0; in_valid = 1'b0;
    take_report("stall");
    check("stall_next_start_clears", 64'(rpt_samples), 64'(WIN));
    begin_win();
    check("restart_samples_zero", 64'(rpt_samples), 64'd0);

    // Reset in the middle of a window discards it
    send(rnd(), 0, 1'b1);
    send(rnd(), 1, 1'b1);
    check("mid_samples", 64'(rpt_samples), 64'd2);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("midrst_busy", 64'(busy), 64'd0);
    check("midrst_valid", 64'(rpt_valid), 64'd0);
    check("midrst_toggles", 64'(rpt_toggles), 64'd0);
    check("midrst_samples", 64'(rpt_samples), 64'd0);
    check("midrst_sig", 64'(rpt_signature), 64'd0);
    check("midrst_max", 64'(rpt_max_cycle), 64'd0);
    repeat (4) @(negedge clk);
    check("midrst_no_report", 64'(rpt_valid), 64'd0);
    begin_win();
    for (int i = 0; i < WIN; i++) v[i] = rnd();
    run_win(v, 2);
    check_report("after_rst");
    take_report("after_rst");

    // Randomised windows, including sparse bit flips
    for (int n = 0; n < 8; n++) begin
      begin_win();
      v[0] = rnd();
      for (int i = 1; i < WIN; i++)
        v[i] = (n % 2 == 0) ? rnd() : (v[i-1] ^ (rnd() & rnd() & rnd()));
      run_win(v, 2);
      check_report("rand");
      repeat ($urandom_range(0, 3)) @(negedge clk);
      take_report("rand");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
